// File: rtl/motor_ramp_ctrl.sv
// Motor duty/direction ramp controller: debounced switch targets, single-LSB
// soft start/stop slewing, and a stop/dead-time/flip sequence for reversals.
module motor_ramp_ctrl #(
    parameter int DEBOUNCE_CYC  = 500_000,
    parameter int RAMP_STEP_CYC = 195_312,
    parameter int DEAD_CYC      = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_dir,
    input  logic [7:0] sw_duty,
    output logic [7:0] duty_out,
    output logic       dir_out,
    output logic       busy,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        STOP  = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam int DB_W   = (DEBOUNCE_CYC  > 1) ? $clog2(DEBOUNCE_CYC)  : 1;
    localparam int PRE_W  = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
    localparam int DEAD_W = (DEAD_CYC      > 1) ? $clog2(DEAD_CYC)      : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_STEP_CYC - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

    logic [8:0]        sync_q1;
    logic [8:0]        sync_q2;
    logic [DB_W-1:0]   db_cnt;
    logic              tgt_dir;
    logic [7:0]        tgt_duty;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        duty_nxt;
    logic              dir_nxt;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_nxt;

    // sync_q1 is the value sync_q2 takes next, so a mismatch between them restarts the count.
    // The count parks at its last value so a long-stable input never rolls over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            db_cnt   <= '0;
            tgt_dir  <= 1'b0;
            tgt_duty <= 8'd0;
        end else begin
            sync_q1 <= {sw_dir, sw_duty};
            sync_q2 <= sync_q1;
            if (sync_q1 != sync_q2)
                db_cnt <= '0;
            else if (db_cnt != DB_LAST)
                db_cnt <= db_cnt + 1'b1;
            if (db_cnt == DB_LAST)
                {tgt_dir, tgt_duty} <= sync_q2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= TRACK;
            duty_out <= 8'd0;
            dir_out  <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            duty_out <= duty_nxt;
            dir_out  <= dir_nxt;
            dead_cnt <= dead_nxt;
        end
    end

    // Direction only changes on the DEAD exit, where duty is already pinned at zero.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_out;
        dir_nxt   = dir_out;
        dead_nxt  = dead_cnt;
        case (state)
            TRACK: begin
                if (tgt_dir != dir_out)
                    state_nxt = STOP;
                else if (tick) begin
                    if (duty_out < tgt_duty)
                        duty_nxt = duty_out + 8'd1;
                    else if (duty_out > tgt_duty)
                        duty_nxt = duty_out - 8'd1;
                end
            end
            STOP: begin
                if (tgt_dir == dir_out)
                    state_nxt = TRACK;
                else if (duty_out == 8'd0) begin
                    state_nxt = DEAD;
                    dead_nxt  = '0;
                end else if (tick)
                    duty_nxt = duty_out - 8'd1;
            end
            DEAD: begin
                duty_nxt = 8'd0;
                if (tgt_dir == dir_out)
                    state_nxt = TRACK;
                else if (dead_cnt == DEAD_LAST) begin
                    dir_nxt   = tgt_dir;
                    state_nxt = TRACK;
                end else
                    dead_nxt = dead_cnt + 1'b1;
            end
            default: state_nxt = TRACK;
        endcase
    end

    always_comb begin
        busy      = (state != TRACK) || (duty_out != tgt_duty);
        state_out = state;
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with short debounce/step/dead timings.
module tb_motor_ramp_ctrl;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       sw_dir  = 1'b0;
    logic [7:0] sw_duty = 8'd0;
    logic [7:0] duty_out;
    logic       dir_out;
    logic       busy;
    logic [1:0] state_out;

    int checks   = 0;
    int failures = 0;

    logic       mon_en = 1'b0;
    logic [7:0] prev_duty;
    logic       prev_dir;
    int         step;

    motor_ramp_ctrl #(
        .DEBOUNCE_CYC (4),
        .RAMP_STEP_CYC(2),
        .DEAD_CYC     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_dir   (sw_dir),
        .sw_duty  (sw_duty),
        .duty_out (duty_out),
        .dir_out  (dir_out),
        .busy     (busy),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Continuous invariants: single-LSB duty steps, and direction only moves at duty 0.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            step = int'(duty_out) - int'(prev_duty);
            checks++;
            if (step > 1 || step < -1) begin
                failures++;
                $display("[TB] FAIL duty_step: duty %0h after %0h, required a change of at most 1", duty_out, prev_duty);
            end
            checks++;
            if (dir_out !== prev_dir && (prev_duty !== 8'd0 || duty_out !== 8'd0)) begin
                failures++;
                $display("[TB] FAIL dir_while_moving: dir %0b -> %0b with duty %0h -> %0h, required duty 0", prev_dir, dir_out, prev_duty, duty_out);
            end
        end
        prev_duty = duty_out;
        prev_dir  = dir_out;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_duty(input logic [7:0] v, input int limit);
        int n = 0;
        while (duty_out !== v && n < limit) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int n);
        n = 0;
        while (state_out !== s && n < limit) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (duty_out !== 8'd0 || dir_out !== 1'b0 || state_out !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: duty %0h dir %0b state %0d busy %0b, required 0 0 0 0", duty_out, dir_out, state_out, busy);
        end
        cyc(3);
        checks++;
        if (duty_out !== 8'd0 || dir_out !== 1'b0 || state_out !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_hold: duty %0h dir %0b state %0d, required 0 0 0", duty_out, dir_out, state_out);
        end
        rst = 1'b1;
        cyc(2);
        mon_en = 1'b1;
        checks++;
        if (duty_out !== 8'd0 || busy !== 1'b0 || state_out !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_release: duty %0h busy %0b state %0d, required 0 0 0", duty_out, busy, state_out);
        end
    endtask

    task automatic test_debounce;
        int n;
        sw_duty = 8'h10;
        cyc(3);
        sw_duty = 8'h00;
        cyc(12);
        checks++;
        if (duty_out !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL debounce_glitch: duty %0h busy %0b, required 0 0", duty_out, busy);
        end
        sw_duty = 8'h10;
        cyc(5);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL debounce_early: busy %0b five cycles after change, required 0", busy);
        end
        cyc(1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL debounce_accept: busy %0b six cycles after change, required 1", busy);
        end
        n = 0;
        while (duty_out !== 8'h10 && n < 40) begin
            cyc(1);
            n++;
        end
        checks++;
        if (duty_out !== 8'h10 || n < 31 || n > 32) begin
            failures++;
            $display("[TB] FAIL ramp_up_time: duty %0h after %0d cycles, required 10 after 31..32", duty_out, n);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ramp_up_busy: busy %0b, required 0", busy);
        end
    endtask

    task automatic test_ramp_retarget;
        logic [7:0] min_duty;
        sw_duty = 8'h08;
        wait_duty(8'h08, 60);
        cyc(4);
        checks++;
        if (duty_out !== 8'h08 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ramp_down: duty %0h busy %0b, required 08 0", duty_out, busy);
        end
        sw_duty = 8'h00;
        wait_duty(8'h06, 40);
        sw_duty  = 8'h0C;
        min_duty = duty_out;
        for (int i = 0; i < 60 && duty_out !== 8'h0C; i++) begin
            cyc(1);
            if (duty_out < min_duty)
                min_duty = duty_out;
        end
        checks++;
        if (min_duty !== 8'h03) begin
            failures++;
            $display("[TB] FAIL retarget_turn: lowest duty %0h, required 03", min_duty);
        end
        cyc(4);
        checks++;
        if (duty_out !== 8'h0C || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL retarget_settle: duty %0h busy %0b, required 0c 0", duty_out, busy);
        end
    endtask

    task automatic test_aborted_reversal;
        int n;
        sw_dir = 1'b1;
        wait_state(2'd2, 80, n);
        checks++;
        if (state_out !== 2'd2 || duty_out !== 8'd0 || dir_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_dead_entry: state %0d duty %0h dir %0b, required 2 0 0", state_out, duty_out, dir_out);
        end
        sw_dir = 1'b0;
        wait_state(2'd0, 20, n);
        checks++;
        if (state_out !== 2'd0 || dir_out !== 1'b0 || n !== 7) begin
            failures++;
            $display("[TB] FAIL abort_dead: state %0d dir %0b after %0d cycles, required 0 0 after 7", state_out, dir_out, n);
        end
        wait_duty(8'h0C, 60);
        checks++;
        if (duty_out !== 8'h0C || dir_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_dead_recover: duty %0h dir %0b busy %0b, required 0c 0 0", duty_out, dir_out, busy);
        end
        sw_dir = 1'b1;
        wait_state(2'd1, 20, n);
        checks++;
        if (state_out !== 2'd1 || duty_out !== 8'h0C) begin
            failures++;
            $display("[TB] FAIL abort_stop_entry: state %0d duty %0h, required 1 0c", state_out, duty_out);
        end
        sw_dir = 1'b0;
        wait_state(2'd0, 20, n);
        checks++;
        if (state_out !== 2'd0 || duty_out !== 8'h09 || dir_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_stop: state %0d duty %0h dir %0b, required 0 09 0", state_out, duty_out, dir_out);
        end
        wait_duty(8'h0C, 40);
        checks++;
        if (duty_out !== 8'h0C || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_stop_recover: duty %0h busy %0b, required 0c 0", duty_out, busy);
        end
    endtask

    task automatic test_reversal;
        int n;
        sw_duty = 8'h20;
        wait_duty(8'h20, 80);
        sw_dir = 1'b1;
        wait_state(2'd1, 20, n);
        checks++;
        if (state_out !== 2'd1 || dir_out !== 1'b0 || duty_out !== 8'h20) begin
            failures++;
            $display("[TB] FAIL rev_stop: state %0d dir %0b duty %0h, required 1 0 20", state_out, dir_out, duty_out);
        end
        wait_state(2'd2, 100, n);
        checks++;
        if (state_out !== 2'd2 || duty_out !== 8'd0 || dir_out !== 1'b0 || n < 64 || n > 66) begin
            failures++;
            $display("[TB] FAIL rev_ramp_down: state %0d duty %0h dir %0b after %0d cycles, required 2 0 0 after 64..66", state_out, duty_out, dir_out, n);
        end
        n = 1;
        for (int i = 0; i < 20 && state_out === 2'd2; i++) begin
            cyc(1);
            if (state_out === 2'd2)
                n++;
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("[TB] FAIL rev_dead_len: %0d cycles in DEAD, required 8", n);
        end
        checks++;
        if (state_out !== 2'd0 || dir_out !== 1'b1 || duty_out !== 8'd0) begin
            failures++;
            $display("[TB] FAIL rev_flip: state %0d dir %0b duty %0h, required 0 1 0", state_out, dir_out, duty_out);
        end
        wait_duty(8'h20, 100);
        checks++;
        if (duty_out !== 8'h20 || dir_out !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rev_ramp_up: duty %0h dir %0b busy %0b, required 20 1 0", duty_out, dir_out, busy);
        end
    endtask

    task automatic test_bounds;
        sw_duty = 8'hFF;
        wait_duty(8'hFF, 600);
        cyc(10);
        checks++;
        if (duty_out !== 8'hFF || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bound_top: duty %0h busy %0b, required ff 0", duty_out, busy);
        end
        sw_duty = 8'h00;
        wait_duty(8'h00, 600);
        cyc(10);
        checks++;
        if (duty_out !== 8'h00 || busy !== 1'b0 || state_out !== 2'd0) begin
            failures++;
            $display("[TB] FAIL bound_bottom: duty %0h busy %0b state %0d, required 0 0 0", duty_out, busy, state_out);
        end
    endtask

    task automatic test_reset_mid_reversal;
        int n;
        sw_duty = 8'h30;
        wait_duty(8'h30, 120);
        sw_dir = 1'b0;
        wait_state(2'd1, 20, n);
        checks++;
        if (state_out !== 2'd1 || duty_out !== 8'h30 || dir_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_setup: state %0d duty %0h dir %0b, required 1 30 1", state_out, duty_out, dir_out);
        end
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        checks++;
        if (duty_out !== 8'd0 || dir_out !== 1'b0 || state_out !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_async: duty %0h dir %0b state %0d busy %0b, required 0 0 0 0", duty_out, dir_out, state_out, busy);
        end
        cyc(3);
        checks++;
        if (duty_out !== 8'd0 || dir_out !== 1'b0 || state_out !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midrst_hold: duty %0h dir %0b state %0d, required 0 0 0", duty_out, dir_out, state_out);
        end
        rst = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_ramp_retarget();
        test_aborted_reversal();
        test_reversal();
        test_bounds();
        test_reset_mid_reversal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
